// File: rtl/tone_detect_pkg.sv
// rtl/tone_detect_pkg.sv - note constants, FSM state type and window helpers
package tone_detect_pkg;

    typedef enum logic [1:0] {
        SILENT = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    typedef logic [2:0] note_t;

    localparam note_t NOTE_NONE = 3'd0;
    localparam note_t NOTE_C4   = 3'd1;
    localparam note_t NOTE_E4   = 3'd2;
    localparam note_t NOTE_G4   = 3'd3;
    localparam note_t NOTE_C5   = 3'd4;

    localparam int  DEF_FREQ  = 2080000;
    localparam real DEF_NOTE1 = 261.626;
    localparam real DEF_NOTE2 = 329.628;
    localparam real DEF_NOTE3 = 391.995;
    localparam real DEF_NOTE4 = 523.251;

    // Nominal period in clk cycles, rounded to nearest.
    function automatic int nominal(input int f, input real note);
        return int'(real'(f) / note);
    endfunction

    function automatic bit windows_overlap(input int lo_a, input int hi_a,
                                           input int lo_b, input int hi_b);
        return (lo_a <= hi_b) && (lo_b <= hi_a);
    endfunction

endpackage

// File: rtl/tone_detect_period_meter.sv
// rtl/tone_detect_period_meter.sv - input synchronizer, rising-edge detect, saturating period counter
module tone_detect_period_meter #(
    parameter int width = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic             edge_p,
    output logic [width-1:0] count,
    output logic             timeout
);

    localparam logic [width-1:0] CNT_MAX = '1;

    // [0],[1] synchronize; [2] is the delayed copy for edge detection.
    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            count  <= '0;
        end else begin
            sync_q <= {sync_q[1:0], sig_in};
            if (edge_p)
                count <= {{(width-1){1'b0}}, 1'b1};
            else if (!timeout)
                count <= count + 1'b1;
        end
    end

    assign edge_p  = sync_q[1] & ~sync_q[2];
    assign timeout = (count == CNT_MAX);

endmodule

// File: rtl/tone_detect.sv
// rtl/tone_detect.sv - classifies measured square-wave period into one of four notes and locks one-hot leds
module tone_detect
    import tone_detect_pkg::*;
#(
    parameter int  freq      = DEF_FREQ,
    parameter real note1     = DEF_NOTE1,
    parameter real note2     = DEF_NOTE2,
    parameter real note3     = DEF_NOTE3,
    parameter real note4     = DEF_NOTE4,
    parameter int  width     = 14,
    parameter int  tol_shift = 4,
    parameter int  confirm   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic             led1,
    output logic             led2,
    output logic             led3,
    output logic             led4,
    output logic             active,
    output logic [width-1:0] period
);

    localparam int NOM1 = nominal(freq, note1);
    localparam int NOM2 = nominal(freq, note2);
    localparam int NOM3 = nominal(freq, note3);
    localparam int NOM4 = nominal(freq, note4);
    localparam int LO1 = NOM1 - (NOM1 >>> tol_shift), HI1 = NOM1 + (NOM1 >>> tol_shift);
    localparam int LO2 = NOM2 - (NOM2 >>> tol_shift), HI2 = NOM2 + (NOM2 >>> tol_shift);
    localparam int LO3 = NOM3 - (NOM3 >>> tol_shift), HI3 = NOM3 + (NOM3 >>> tol_shift);
    localparam int LO4 = NOM4 - (NOM4 >>> tol_shift), HI4 = NOM4 + (NOM4 >>> tol_shift);
    localparam int MW  = $clog2(confirm + 1);

    localparam bit OVERLAP =
        windows_overlap(LO1, HI1, LO2, HI2) || windows_overlap(LO1, HI1, LO3, HI3) ||
        windows_overlap(LO1, HI1, LO4, HI4) || windows_overlap(LO2, HI2, LO3, HI3) ||
        windows_overlap(LO2, HI2, LO4, HI4) || windows_overlap(LO3, HI3, LO4, HI4);

    if (OVERLAP) begin : g_overlap
        $error("tone_detect: note windows overlap");
    end

    logic             edge_p;
    logic             timeout;
    logic [width-1:0] count;

    tone_detect_period_meter #(.width(width)) u_meter (
        .clk     (clk),
        .rst_n   (rst_n),
        .sig_in  (sig_in),
        .edge_p  (edge_p),
        .count   (count),
        .timeout (timeout)
    );

    logic [31:0] cnt32;
    note_t       cls;

    assign cnt32 = 32'(count);

    always_comb begin
        cls = NOTE_NONE;
        if (cnt32 >= 32'(LO1) && cnt32 <= 32'(HI1)) cls = NOTE_C4;
        if (cnt32 >= 32'(LO2) && cnt32 <= 32'(HI2)) cls = NOTE_E4;
        if (cnt32 >= 32'(LO3) && cnt32 <= 32'(HI3)) cls = NOTE_G4;
        if (cnt32 >= 32'(LO4) && cnt32 <= 32'(HI4)) cls = NOTE_C5;
    end

    state_t           state_q, state_d;
    note_t            cand_q, cand_d;
    logic [MW-1:0]    match_q, match_d;
    logic [3:0]       led_q, led_d;
    logic             active_q;
    logic [width-1:0] period_q, period_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SILENT;
            cand_q   <= NOTE_NONE;
            match_q  <= '0;
            led_q    <= '0;
            active_q <= 1'b0;
            period_q <= '0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            match_q  <= match_d;
            led_q    <= led_d;
            active_q <= |led_d;
            period_q <= period_d;
        end
    end

    // cand_q doubles as the locked note while in LOCKED.
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        match_d  = match_q;
        led_d    = led_q;
        period_d = period_q;
        if (edge_p) begin
            case (state_q)
                SILENT: begin
                    state_d = ARMED;
                    cand_d  = NOTE_NONE;
                    match_d = '0;
                end
                ARMED: begin
                    period_d = count;
                    if (cls != NOTE_NONE && cls == cand_q) begin
                        match_d = match_q + 1'b1;
                        if (int'(match_q) + 1 >= confirm) begin
                            state_d = LOCKED;
                            led_d   = 4'b0001 << (cls - 3'd1);
                        end
                    end else begin
                        cand_d  = cls;
                        match_d = MW'(cls != NOTE_NONE);
                    end
                end
                LOCKED: begin
                    period_d = count;
                    if (cls != cand_q) begin
                        state_d = ARMED;
                        led_d   = '0;
                        cand_d  = cls;
                        match_d = MW'(cls != NOTE_NONE);
                    end
                end
                default: state_d = SILENT;
            endcase
        end else if (timeout) begin
            state_d = SILENT;
            led_d   = '0;
            cand_d  = NOTE_NONE;
            match_d = '0;
        end
    end

    always_comb begin
        led1   = led_q[0];
        led2   = led_q[1];
        led3   = led_q[2];
        led4   = led_q[3];
        active = active_q;
        period = period_q;
    end

endmodule
